sift_result_writer: RTL and testbench

- Sink end of the Gaussian/DoG window pipeline.
- Takes the raster-ordered stream of filtered pixels produced once per accepted window position.
- Generates the write address, write enable and write data for the result image RAM, realigning every result to its window-centre coordinate.
- Counterpart of the upstream window extractor: that block reads the source RAM with a linear address counter; this block writes the result RAM with one.

---
 rtl/sift_img_pkg.sv | 24 ++
 rtl/raster_pos_counter.sv | 34 +++
 rtl/sift_result_writer.sv | 142 ++++++++++++++
 tb/tb_sift_result_writer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_img_pkg.sv
// Shared image geometry, pixel/address types and writer state encoding for the
// SIFT Gaussian/DoG window pipeline.
package sift_img_pkg;

  localparam int IMG_W  = 512;
  localparam int IMG_H  = 512;
  localparam int WIN    = 11;
  localparam int HALF   = (WIN - 1) / 2;
  localparam int OFFSET = HALF * IMG_W + HALF;
  localparam int DW     = 8;
  localparam int AW     = 18;
  localparam int KW     = 19;

  typedef logic [DW-1:0] pixel_t;
  typedef logic [AW-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/raster_pos_counter.sv
// Raster position tracker: linear index k plus column/row, column wrapping at
// the end of each image line. Shared by the window extractor and result writer.
module raster_pos_counter #(
  parameter int IMG_W = 512,
  parameter int KW    = 19,
  parameter int CW    = 9,
  parameter int RW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [KW-1:0] k,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      k   <= '0;
      col <= '0;
      row <= '0;
    end else if (en) begin
      k <= k + KW'(1);
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sift_result_writer.sv
// Result RAM writer: realigns each filtered pixel to its window-centre address.
// Build option BORDER_FILL_EN zero-fills border slots and adds a trailing FLUSH.
module sift_result_writer #(
  parameter int IMG_W = sift_img_pkg::IMG_W,
  parameter int IMG_H = sift_img_pkg::IMG_H,
  parameter int WIN   = sift_img_pkg::WIN,
  parameter int DW    = sift_img_pkg::DW,
  parameter int AW    = sift_img_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          complete,
  output logic          err
);

  import sift_img_pkg::*;

  localparam int HALF   = (WIN - 1) / 2;
  localparam int OFFSET = HALF * IMG_W + HALF;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int KW     = 19;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int EDGE   = WIN - 1;

  localparam logic [KW-1:0] OFFSET_K = KW'(OFFSET);
  localparam logic [KW-1:0] LAST_K   = KW'(NPIX - 1);
`ifdef BORDER_FILL_EN
  localparam logic [KW-1:0] FLUSH_LAST_K = KW'(NPIX + OFFSET - 1);
`endif

  wr_state_e     state;
  logic [KW-1:0] k;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          clr;
  logic          cnt_en;
  logic          past_offset;
  logic          interior;
  logic [AW-1:0] addr_next;

  assign accept      = (state == RUN) && din_valid;
  assign clr         = start && ((state == IDLE) || (state == DONE));
  assign past_offset = (k >= OFFSET_K);
  // Subtraction result is only consumed when past_offset, so it never wraps.
  assign addr_next   = AW'(k - OFFSET_K);
  assign interior    = (row >= RW'(EDGE)) && (col >= CW'(EDGE));

`ifdef BORDER_FILL_EN
  // The flush phase keeps counting k beyond the frame to walk the tail addresses.
  assign cnt_en = accept || (state == FLUSH);
`else
  assign cnt_en = accept;
`endif

  raster_pos_counter #(
    .IMG_W (IMG_W),
    .KW    (KW),
    .CW    (CW),
    .RW    (RW)
  ) u_pos (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (cnt_en),
    .k   (k),
    .col (col),
    .row (row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      complete <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (din_valid && (state != RUN)) err <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            complete <= 1'b0;
          end
        end
        RUN: begin
          if (din_valid) begin
            if (past_offset) begin
`ifdef BORDER_FILL_EN
              wr_en   <= 1'b1;
              wr_addr <= addr_next;
              wr_data <= interior ? din : '0;
`else
              if (interior) begin
                wr_en   <= 1'b1;
                wr_addr <= addr_next;
                wr_data <= din;
              end
`endif
            end
            if (k == LAST_K) begin
`ifdef BORDER_FILL_EN
              state <= FLUSH;
`else
              state    <= DONE;
              busy     <= 1'b0;
              complete <= 1'b1;
`endif
            end
          end
        end
`ifdef BORDER_FILL_EN
        FLUSH: begin
          wr_en   <= 1'b1;
          wr_addr <= addr_next;
          wr_data <= '0;
          if (k == FLUSH_LAST_K) begin
            state    <= DONE;
            busy     <= 1'b0;
            complete <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sift_result_writer.sv
// Directed self-checking bench for sift_result_writer on a reduced 64x48 image.
module tb_sift_result_writer;

  localparam int IMG_W  = 64;
  localparam int IMG_H  = 48;
  localparam int WIN    = 11;
  localparam int DW     = 8;
  localparam int AW     = 12;
  localparam int OFFSET = 325;
  localparam int NPIX   = 3072;
`ifdef BORDER_FILL_EN
  localparam bit FILL      = 1'b1;
  localparam int EXP_W     = 3072;
  localparam int LAST_ADDR = 3071;
`else
  localparam bit FILL      = 1'b0;
  localparam int EXP_W     = 2052;
  localparam int LAST_ADDR = 2746;
`endif

  logic          clk = 1'b0;
  logic          rst, start, din_valid;
  logic [DW-1:0] din;
  logic          wr_en, busy, complete, err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sift_result_writer #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .WIN (WIN), .DW (DW), .AW (AW)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .din_valid (din_valid), .din (din),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .busy (busy), .complete (complete), .err (err)
  );

  // Write monitor: checks every observed write against the address-derived model.
  bit  mon_on = 1'b0;
  bit  seen [NPIX];
  int  m_writes, m_bad, m_slot, m_dup, m_order, m_last, cmp_after_last;
  bit  prev_last;
  int  ma, mk, mrow, mcol;
  bit  mint;

  always @(negedge clk) begin
    if (mon_on) begin
      if (prev_last) cmp_after_last = int'(complete);
      prev_last = 1'b0;
      if (wr_en === 1'b1) begin
        ma   = int'(wr_addr);
        mk   = ma + OFFSET;
        mrow = mk / IMG_W;
        mcol = mk % IMG_W;
        mint = (mk < NPIX) && (mrow >= WIN - 1) && (mcol >= WIN - 1);
        m_writes++;
        if (!(mint || FILL)) m_slot++;
        if (wr_data !== (mint ? 8'(mk) : 8'd0)) m_bad++;
        if (ma < NPIX) begin
          if (seen[ma]) m_dup++;
          seen[ma] = 1'b1;
        end else m_slot++;
        if (ma <= m_last) m_order++;
        m_last = ma;
        if (ma == LAST_ADDR) prev_last = 1'b1;
      end
    end
  end

  logic [20:0] s324, s325, s650;
  int gap_viol;

  task automatic clear_mon();
    mon_on = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    m_writes = 0; m_bad = 0; m_slot = 0; m_dup = 0; m_order = 0;
    m_last = -1; cmp_after_last = -1; prev_last = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drive_frame(input bit toggle, input int start_at, input int stop_k);
    int  k;
    bit  last_v;
    bit  v;
    k = 0; last_v = 1'b0; gap_viol = 0;
    s324 = 'x; s325 = 'x; s650 = 'x;
    while (k < stop_k) begin
      @(negedge clk);
      if (last_v) begin
        if (k - 1 == 324) s324 = {wr_en, wr_addr, wr_data};
        if (k - 1 == 325) s325 = {wr_en, wr_addr, wr_data};
        if (k - 1 == 650) s650 = {wr_en, wr_addr, wr_data};
      end else if (toggle && k > 0) begin
        gap_viol += int'(wr_en);
      end
      v = toggle ? !last_v : 1'b1;
      din_valid = v;
      din       = k[7:0];
      start     = v && (k == start_at);
      if (v) k++;
      last_v = v;
    end
    @(negedge clk);
    din_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_complete(output bit ok);
    int n;
    n = 0;
    while (complete !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (complete === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %0b want 0", wr_en); else n_pass++;
    n_checks++; if (wr_addr !== '0) $display("FAIL reset_wr_addr got %0d want 0", wr_addr); else n_pass++;
    n_checks++; if (wr_data !== '0) $display("FAIL reset_wr_data got %0d want 0", wr_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (complete !== 1'b0) $display("FAIL reset_complete got %0b want 0", complete); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %0b want 0", err); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    bit ok;
    clear_mon();
    pulse_start();
    n_checks++; if (busy !== 1'b1) $display("FAIL cont_busy_start got %0b want 1", busy); else n_pass++;
    drive_frame(1'b0, -1, NPIX);
    wait_complete(ok);
    repeat (2) @(negedge clk);
    n_checks++; if (s324[20] !== 1'b0) $display("FAIL cont_k324_en got %0b want 0", s324[20]); else n_pass++;
    n_checks++; if (s325[20] !== FILL || (s325[20] && s325[19:0] !== 20'd0))
      $display("FAIL cont_k325 got %h want en=%0b addr=0 data=0", s325, FILL); else n_pass++;
    n_checks++; if (s650 !== {1'b1, 12'd325, 8'h8A}) $display("FAIL cont_k650 got %h want %h", s650, {1'b1, 12'd325, 8'h8A}); else n_pass++;
    n_checks++; if (m_writes !== EXP_W) $display("FAIL cont_writes got %0d want %0d", m_writes, EXP_W); else n_pass++;
    n_checks++; if (m_slot !== 0) $display("FAIL cont_bad_slot got %0d want 0", m_slot); else n_pass++;
    n_checks++; if (m_bad !== 0) $display("FAIL cont_bad_data got %0d want 0", m_bad); else n_pass++;
    n_checks++; if (m_dup !== 0) $display("FAIL cont_dup got %0d want 0", m_dup); else n_pass++;
    n_checks++; if (m_order !== 0) $display("FAIL cont_order got %0d want 0", m_order); else n_pass++;
    n_checks++; if (!ok) $display("FAIL cont_complete_timeout got %0b want 1", complete); else n_pass++;
    n_checks++; if (cmp_after_last !== 1) $display("FAIL cont_complete_after_last got %0d want 1", cmp_after_last); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL cont_busy_done got %0b want 0", busy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL cont_err got %0b want 0", err); else n_pass++;
  endtask

  task automatic test_toggle();
    bit ok;
    clear_mon();
    pulse_start();
    drive_frame(1'b1, -1, NPIX);
    wait_complete(ok);
    repeat (2) @(negedge clk);
    n_checks++; if (m_writes !== EXP_W) $display("FAIL tog_writes got %0d want %0d", m_writes, EXP_W); else n_pass++;
    n_checks++; if (m_bad !== 0) $display("FAIL tog_bad_data got %0d want 0", m_bad); else n_pass++;
    n_checks++; if (m_slot !== 0 || m_dup !== 0) $display("FAIL tog_slot_dup got %0d/%0d want 0/0", m_slot, m_dup); else n_pass++;
    n_checks++; if (m_order !== 0) $display("FAIL tog_order got %0d want 0", m_order); else n_pass++;
    n_checks++; if (gap_viol !== 0) $display("FAIL tog_gap_wr_en got %0d want 0", gap_viol); else n_pass++;
    n_checks++; if (!ok) $display("FAIL tog_complete got %0b want 1", complete); else n_pass++;
  endtask

  task automatic test_start_in_run();
    bit ok;
    clear_mon();
    pulse_start();
    drive_frame(1'b0, 1500, NPIX);
    wait_complete(ok);
    repeat (2) @(negedge clk);
    n_checks++; if (m_writes !== EXP_W) $display("FAIL srun_writes got %0d want %0d", m_writes, EXP_W); else n_pass++;
    n_checks++; if (m_dup !== 0) $display("FAIL srun_dup got %0d want 0", m_dup); else n_pass++;
    n_checks++; if (m_order !== 0) $display("FAIL srun_order got %0d want 0", m_order); else n_pass++;
    n_checks++; if (m_bad !== 0) $display("FAIL srun_bad_data got %0d want 0", m_bad); else n_pass++;
    n_checks++; if (!ok) $display("FAIL srun_complete got %0b want 1", complete); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL srun_err got %0b want 0", err); else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int w0;
    clear_mon();
    pulse_start();
    drive_frame(1'b0, -1, 2000);
    rst = 1'b1; din_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; start = 1'b0;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL mrst_wr_en got %0b want 0", wr_en); else n_pass++;
    n_checks++; if (wr_addr !== '0) $display("FAIL mrst_wr_addr got %0d want 0", wr_addr); else n_pass++;
    n_checks++; if (wr_data !== '0) $display("FAIL mrst_wr_data got %0d want 0", wr_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mrst_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (complete !== 1'b0) $display("FAIL mrst_complete got %0b want 0", complete); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL mrst_err got %0b want 0", err); else n_pass++;
    w0 = m_writes;
    repeat (5) @(negedge clk);
    n_checks++; if (m_writes !== w0) $display("FAIL mrst_no_writes got %0d want %0d", m_writes, w0); else n_pass++;
    clear_mon();
    pulse_start();
    drive_frame(1'b0, -1, NPIX);
    wait_complete(ok);
    repeat (2) @(negedge clk);
    n_checks++; if (m_writes !== EXP_W) $display("FAIL mrst_writes got %0d want %0d", m_writes, EXP_W); else n_pass++;
    n_checks++; if (m_bad !== 0 || m_slot !== 0) $display("FAIL mrst_bad got %0d/%0d want 0/0", m_bad, m_slot); else n_pass++;
    n_checks++; if (m_dup !== 0 || m_order !== 0) $display("FAIL mrst_dup_order got %0d/%0d want 0/0", m_dup, m_order); else n_pass++;
    n_checks++; if (!ok) $display("FAIL mrst_complete got %0b want 1", complete); else n_pass++;
  endtask

  task automatic test_err();
    int w0;
    w0 = m_writes;
    @(negedge clk); din_valid = 1'b1; din = 8'h55;
    @(negedge clk); din_valid = 1'b0;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL err_done_wr_en got %0b want 0", wr_en); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL err_done_set got %0b want 1", err); else n_pass++;
    n_checks++; if (complete !== 1'b1) $display("FAIL err_done_complete got %0b want 1", complete); else n_pass++;
    pulse_start();
    repeat (3) @(negedge clk);
    n_checks++; if (err !== 1'b1) $display("FAIL err_held got %0b want 1", err); else n_pass++;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++; if (err !== 1'b0) $display("FAIL err_cleared got %0b want 0", err); else n_pass++;
    @(negedge clk); din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    n_checks++; if (err !== 1'b1) $display("FAIL err_idle_set got %0b want 1", err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL err_idle_busy got %0b want 0", busy); else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++; if (err !== 1'b1) $display("FAIL err_idle_held got %0b want 1", err); else n_pass++;
    n_checks++; if (m_writes !== w0) $display("FAIL err_no_writes got %0d want %0d", m_writes, w0); else n_pass++;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_toggle();
    test_start_in_run();
    test_mid_reset();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
